// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec -- execute stage feeding the register file write port.
//
// Consumes the two register-file read ports as operands together with a
// decoded ALU opcode and produces a registered result, destination address
// and a one-cycle write strobe. Single-cycle ops finish on the issuing edge;
// MUL runs an iterative shift-add over WIDTH clocks and raises busy while it
// iterates.
//
// Optional feature macro: ALU_FLAGS_EN
//   defined   -> registered Z/C/N flag outputs are present
//   undefined -> flag ports and their logic are absent
//
// Handshake: an op is accepted on a rising CLK edge when start is high and
// busy is low. While busy is high, start is ignored entirely (no queueing).
// write_enable is high for exactly one cycle per completed op.
//
// Ports:
//   CLK          in   rising-edge clock
//   nRST         in   asynchronous active-low reset
//   start        in   issue request
//   ALUOp[3:0]   in   0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SHL 6 SHR 7 MUL 8 MOVB
//   SrcA, SrcB   in   operands (RD1, RD2)
//   WA_in        in   destination register of the issued op
//   busy         out  high while MUL iterates
//   ALUResult    out  registered result
//   WA           out  registered destination
//   write_enable out  registered one-cycle write strobe
//   Z, C, N      out  flags (ALU_FLAGS_EN only)
// ---------------------------------------------------------------------------
module alu_exec #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic [3:0]        ALUOp,
    input  logic [WIDTH-1:0]  SrcA,
    input  logic [WIDTH-1:0]  SrcB,
    input  logic [ADDR_W-1:0] WA_in,
    output logic              busy,
    output logic [WIDTH-1:0]  ALUResult,
    output logic [ADDR_W-1:0] WA,
    output logic              write_enable
`ifdef ALU_FLAGS_EN
    ,
    output logic              Z,
    output logic              C,
    output logic              N
`endif
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_MOVB = 4'd8;

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // State and output registers
    state_t              state_q,  state_d;
    logic                busy_q,   busy_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [ADDR_W-1:0]   wa_q,     wa_d;
    logic                we_q,     we_d;

    // Multiplier datapath: multiplicand shifts left, multiplier shifts right,
    // so each step only ever inspects bit 0 of the multiplier.
    logic [2*WIDTH-1:0]  mcand_q,  mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [2*WIDTH-1:0]  acc_q,    acc_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [ADDR_W-1:0]   mwa_q,    mwa_d;
    logic [2*WIDTH-1:0]  acc_step;

    // Single-cycle op decode
    logic [2:0]          shamt;
    logic [WIDTH-1:0]    op_res;
    logic                op_simple;

    assign shamt    = SrcB[2:0];
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        op_res    = '0;
        op_simple = 1'b1;
        case (ALUOp)
            OP_ADD:  op_res = SrcA + SrcB;
            OP_SUB:  op_res = SrcA - SrcB;
            OP_AND:  op_res = SrcA & SrcB;
            OP_OR:   op_res = SrcA | SrcB;
            OP_XOR:  op_res = SrcA ^ SrcB;
            OP_SHL:  op_res = SrcA << shamt;
            OP_SHR:  op_res = SrcA >> shamt;
            OP_MOVB: op_res = SrcB;
            default: op_simple = 1'b0;   // MUL and invalid codes
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic                z_q, z_d;
    logic                c_q, c_d;
    logic                n_q, n_d;
    logic                op_c;
    logic [WIDTH:0]      add_ext;
    logic [WIDTH:0]      shl_ext;
    logic [WIDTH:0]      shr_ext;

    assign add_ext = {1'b0, SrcA} + {1'b0, SrcB};
    // One guard bit on the outgoing side captures the last bit shifted out;
    // a zero shift leaves the guard bit at 0.
    assign shl_ext = {1'b0, SrcA} << shamt;
    assign shr_ext = {SrcA, 1'b0} >> shamt;

    always_comb begin
        op_c = 1'b0;
        case (ALUOp)
            OP_ADD:  op_c = add_ext[WIDTH];
            OP_SUB:  op_c = (SrcA < SrcB);
            OP_SHL:  op_c = shl_ext[WIDTH];
            OP_SHR:  op_c = shr_ext[0];
            default: op_c = 1'b0;
        endcase
    end
`endif

    // Next-state / output logic
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        result_d = result_q;
        wa_d     = wa_q;
        we_d     = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mwa_d    = mwa_q;
`ifdef ALU_FLAGS_EN
        z_d      = z_q;
        c_d      = c_q;
        n_d      = n_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (ALUOp == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, SrcA};
                        mplier_d = SrcB;
                        acc_d    = '0;
                        cnt_d    = '0;
                        mwa_d    = WA_in;
                        busy_d   = 1'b1;
                        state_d  = ST_MUL;
                    end else if (op_simple) begin
                        result_d = op_res;
                        wa_d     = WA_in;
                        we_d     = 1'b1;
`ifdef ALU_FLAGS_EN
                        z_d      = (op_res == '0);
                        n_d      = op_res[WIDTH-1];
                        c_d      = op_c;
`endif
                    end
                    // Invalid opcodes: no strobe, result and WA hold.
                end
            end
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // The final step's sum is written straight out on the same edge.
                if (cnt_q == CNT_LAST) begin
                    result_d = acc_step[WIDTH-1:0];
                    wa_d     = mwa_q;
                    we_d     = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
`ifdef ALU_FLAGS_EN
                    z_d      = (acc_step[WIDTH-1:0] == '0);
                    n_d      = acc_step[WIDTH-1];
                    c_d      = |acc_step[2*WIDTH-1:WIDTH];
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            result_q <= '0;
            wa_q     <= '0;
            we_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            mwa_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            wa_q     <= wa_d;
            we_q     <= we_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mwa_q    <= mwa_d;
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            z_q <= 1'b0;
            c_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            z_q <= z_d;
            c_q <= c_d;
            n_q <= n_d;
        end
    end

    assign Z = z_q;
    assign C = c_q;
    assign N = n_q;
`endif

    assign busy         = busy_q;
    assign ALUResult    = result_q;
    assign WA           = wa_q;
    assign write_enable = we_q;

endmodule

// File: tb/tb_alu_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_exec -- self-checking bench for alu_exec (WIDTH=8, ADDR_W=4).
// Inputs change on the falling edge; outputs are compared 1ns after each
// rising edge against a cycle-level reference model built from plain
// arithmetic. Flag checks are compiled in with ALU_FLAGS_EN.
// ---------------------------------------------------------------------------
module tb_alu_exec;

    logic       CLK;
    logic       nRST;
    logic       start;
    logic [3:0] ALUOp;
    logic [7:0] SrcA;
    logic [7:0] SrcB;
    logic [3:0] WA_in;
    logic       busy;
    logic [7:0] ALUResult;
    logic [3:0] WA;
    logic       write_enable;
`ifdef ALU_FLAGS_EN
    logic       Z;
    logic       C;
    logic       N;
`endif

    alu_exec #(.WIDTH(8), .ADDR_W(4)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .start        (start),
        .ALUOp        (ALUOp),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .WA_in        (WA_in),
        .busy         (busy),
        .ALUResult    (ALUResult),
        .WA           (WA),
        .write_enable (write_enable)
`ifdef ALU_FLAGS_EN
        ,
        .Z            (Z),
        .C            (C),
        .N            (N)
`endif
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Counters
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int unsigned m_res, m_wa, m_we, m_busy, m_rem, m_prod, m_pwa;
    int unsigned m_z, m_c, m_n;

    function automatic void model_reset();
        m_res = 0; m_wa = 0; m_we = 0; m_busy = 0; m_rem = 0;
        m_prod = 0; m_pwa = 0; m_z = 0; m_c = 0; m_n = 0;
    endfunction

    function automatic void model_write(int unsigned res, int unsigned wa, int unsigned c);
        m_res = res & 32'hFF;
        m_wa  = wa;
        m_we  = 1;
        m_z   = (m_res == 0) ? 1 : 0;
        m_n   = (m_res >> 7) & 1;
        m_c   = c;
    endfunction

    // One rising edge of the reference model with the inputs applied.
    function automatic void model_step(bit st, int unsigned op, int unsigned a,
                                       int unsigned b, int unsigned wa);
        int unsigned s;
        m_we = 0;
        s = b % 8;
        if (m_busy != 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_busy = 0;
                model_write(m_prod, m_pwa, ((m_prod >> 8) != 0) ? 1 : 0);
            end
        end else if (st) begin
            case (op)
                0: model_write(a + b, wa, (a + b > 255) ? 1 : 0);
                1: model_write(a + 256 - b, wa, (a < b) ? 1 : 0);
                2: model_write(a & b, wa, 0);
                3: model_write(a | b, wa, 0);
                4: model_write(a ^ b, wa, 0);
                5: model_write(a << s, wa, (s == 0) ? 0 : ((a >> (8 - s)) & 1));
                6: model_write(a >> s, wa, (s == 0) ? 0 : ((a >> (s - 1)) & 1));
                7: begin
                    m_busy = 1;
                    m_rem  = 8;
                    m_prod = a * b;
                    m_pwa  = wa;
                end
                8: model_write(b, wa, 0);
                default: ;
            endcase
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".busy"}, 16'(busy),         16'(m_busy));
        check({tag, ".res"},  16'(ALUResult),    16'(m_res));
        check({tag, ".wa"},   16'(WA),           16'(m_wa));
        check({tag, ".we"},   16'(write_enable), 16'(m_we));
`ifdef ALU_FLAGS_EN
        check({tag, ".z"},    16'(Z),            16'(m_z));
        check({tag, ".c"},    16'(C),            16'(m_c));
        check({tag, ".n"},    16'(N),            16'(m_n));
`endif
    endtask

    // Drive one cycle, step the model on the rising edge, compare after it.
    task automatic cyc(input string tag, input bit st, input int unsigned op,
                       input int unsigned a, input int unsigned b, input int unsigned wa);
        @(negedge CLK);
        start = st;
        ALUOp = 4'(op);
        SrcA  = 8'(a);
        SrcB  = 8'(b);
        WA_in = 4'(wa);
        @(posedge CLK);
        model_step(st, op, a, b, wa);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, 0, 0, 0, 0);
    endtask

    int we_count;
    int busy_count;

    initial begin
        nRST  = 1'b0;
        start = 1'b0;
        ALUOp = '0;
        SrcA  = '0;
        SrcB  = '0;
        WA_in = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        compare_all("reset");
        @(negedge CLK);
        nRST = 1'b1;
        idle("post_reset");

        // ADD with carry out
        cyc("add", 1'b1, 0, 8'hF0, 8'h20, 5);
        check("add_res_const", 16'(ALUResult), 16'h0010);
        check("add_wa_const",  16'(WA),        16'h0005);
        check("add_we_const",  16'(write_enable), 16'h0001);
`ifdef ALU_FLAGS_EN
        check("add_c_const", 16'(C), 16'h0001);
        check("add_z_const", 16'(Z), 16'h0000);
`endif
        idle("add_after");
        check("add_we_drop", 16'(write_enable), 16'h0000);

        // Back-to-back SUB then XOR
        cyc("sub", 1'b1, 1, 3, 5, 2);
        check("sub_res_const", 16'(ALUResult), 16'h00FE);
        cyc("xor", 1'b1, 4, 8'hAA, 8'hFF, 3);
        check("xor_res_const", 16'(ALUResult), 16'h0055);
        check("xor_we_const",  16'(write_enable), 16'h0001);
        idle("b2b_after");

        // MUL 13*11 with a start attempted while busy
        we_count   = 0;
        busy_count = 0;
        cyc("mul_issue", 1'b1, 7, 13, 11, 7);
        if (busy) busy_count++;
        for (int i = 0; i < 8; i++) begin
            cyc("mul_iter", (i == 3), 0, 8'h11, 8'h22, 9);
            if (busy) busy_count++;
            if (write_enable) we_count++;
        end
        check("mul_res_const", 16'(ALUResult), 16'h008F);
        check("mul_wa_const",  16'(WA),        16'h0007);
        idle("mul_after");
        if (write_enable) we_count++;
        check("mul_strobes", 16'(we_count),   16'd1);
        check("mul_busy_len", 16'(busy_count), 16'd8);

        // Shifts: upper SrcB bits ignored; zero shift leaves A unchanged
        cyc("shl", 1'b1, 5, 8'h81, 8'hF9, 4);
        check("shl_res_const", 16'(ALUResult), 16'h0002);
`ifdef ALU_FLAGS_EN
        check("shl_c_const", 16'(C), 16'h0001);
`endif
        cyc("shr0", 1'b1, 6, 8'hB7, 8'h08, 6);
        check("shr0_res_const", 16'(ALUResult), 16'h00B7);
`ifdef ALU_FLAGS_EN
        check("shr0_c_const", 16'(C), 16'h0000);
`endif

        // Invalid opcode: no strobe, outputs hold
        cyc("invalid", 1'b1, 12, 8'h12, 8'h34, 9);
        check("inv_we_const",  16'(write_enable), 16'h0000);
        check("inv_res_const", 16'(ALUResult),    16'h00B7);
        check("inv_wa_const",  16'(WA),           16'h0006);

        // MOVB to address 0 still strobes
        cyc("movb_wa0", 1'b1, 8, 8'h00, 8'h5C, 0);
        check("movb_we_const", 16'(write_enable), 16'h0001);

        // Randomized traffic including starts while busy and invalid codes
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 9) < 7), $urandom_range(0, 15),
                $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15));
        end
        repeat (10) idle("rand_drain");

        // Reset in the middle of a MUL: everything clears, no late strobe
        cyc("rst_mul_issue", 1'b1, 7, 8'hFF, 8'hFF, 8);
        idle("rst_mul_1");
        idle("rst_mul_2");
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        model_reset();
        compare_all("rst_mid_mul");
        @(negedge CLK);
        nRST = 1'b1;
        we_count = 0;
        for (int i = 0; i < 12; i++) begin
            idle("rst_after");
            if (write_enable) we_count++;
        end
        check("rst_no_strobe", 16'(we_count), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
